// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared definitions for the pooling/unpooling stages
package pool_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  // Divide-by-4 for a 2x2 block, shared with the pooling stage.
  localparam int POOL_SHIFT = 2;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    EMIT_A = 2'd1,
    EMIT_B = 2'd2
  } unpool_state_e;

endpackage

// File: rtl/unpool_row_buffer.sv
// rtl/unpool_row_buffer.sv - one pooled row of scaled values, async read
module unpool_row_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ROW_LEN    = 4,
  parameter int IDX_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [ROW_LEN];
  logic [DATA_WIDTH-1:0] mem_d [ROW_LEN];

  // Next contents: write the addressed entry, everything else holds.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < ROW_LEN; i++) begin
      if (wr_en && (wr_idx == IDX_W'(i))) begin
        mem_d[i] = wr_data;
      end
    end
  end

  // Only entry 0 is cleared so the idle output reads a defined zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read mux written as a compare chain so any ROW_LEN indexes cleanly.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < ROW_LEN; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_data = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/avgunpool_stream.sv
// rtl/avgunpool_stream.sv - streaming 2x2 average unpooling
module avgunpool_stream
  import pool_pkg::*;
#(
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int ROW_LEN    = 4,
  localparam int COL_WIDTH  = $clog2(2*ROW_LEN) + 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  input  logic [DATA_WIDTH-1:0] In_Value,
  output logic                  Out_Valid,
  input  logic                  Out_Ready,
  output logic [DATA_WIDTH-1:0] Out_Value,
  output logic                  Out_Row_End
);

  localparam int IDX_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(ROW_LEN - 1);
  localparam logic [COL_WIDTH-1:0] LAST_BEAT = COL_WIDTH'(2*ROW_LEN - 1);

  unpool_state_e         state_q, state_d;
  logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
  logic [COL_WIDTH-1:0]  beat_q, beat_d;
  logic                  in_fire, out_fire;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_data;

  // Handshake decode from registered state only.
  always_comb begin
    In_Ready    = (state_q == FILL);
    Out_Valid   = (state_q != FILL);
    Out_Row_End = (state_q != FILL) && (beat_q == LAST_BEAT);
    in_fire     = In_Valid && In_Ready;
    out_fire    = Out_Valid && Out_Ready;
    rd_idx      = IDX_W'(beat_q >> 1);
    Out_Value   = rd_data;
  end

  // Next state: fill one row, then replay it twice at double width.
  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    beat_d   = beat_q;
    case (state_q)
      FILL: begin
        if (in_fire) begin
          if (wr_idx_q == LAST_IDX) begin
            wr_idx_d = '0;
            state_d  = EMIT_A;
          end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
          end
        end
      end
      EMIT_A, EMIT_B: begin
        if (out_fire) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = (state_q == EMIT_A) ? EMIT_B : FILL;
          end else begin
            beat_d = beat_q + COL_WIDTH'(1);
          end
        end
      end
      default: begin
        state_d  = FILL;
        wr_idx_d = '0;
        beat_d   = '0;
      end
    endcase
  end

  // State, write index and beat registers; reset drops any partial row.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= FILL;
      wr_idx_q <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      beat_q   <= beat_d;
    end
  end

  unpool_row_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .ROW_LEN    (ROW_LEN),
    .IDX_W      (IDX_W)
  ) u_row_buffer (
    .clk     (Clock),
    .rst     (Reset),
    .wr_en   (in_fire),
    .wr_idx  (wr_idx_q),
    .wr_data (In_Value >> POOL_SHIFT),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_avgunpool_stream.sv
// tb/tb_avgunpool_stream.sv - directed table-driven bench for avgunpool_stream
module tb_avgunpool_stream;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, in_ready, out_valid, out_ready, out_row_end;
  logic [31:0] in_value, out_value;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, out_row_end1;
  logic [31:0] in_value1, out_value1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] din  [4];
    logic [31:0] dout [4];
    int          mode;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  avgunpool_stream #(.DATA_WIDTH(32), .ROW_LEN(4)) dut (
    .Clock       (clk),
    .Reset       (rst),
    .In_Valid    (in_valid),
    .In_Ready    (in_ready),
    .In_Value    (in_value),
    .Out_Valid   (out_valid),
    .Out_Ready   (out_ready),
    .Out_Value   (out_value),
    .Out_Row_End (out_row_end)
  );

  avgunpool_stream #(.DATA_WIDTH(32), .ROW_LEN(1)) dut1 (
    .Clock       (clk),
    .Reset       (rst),
    .In_Valid    (in_valid1),
    .In_Ready    (in_ready1),
    .In_Value    (in_value1),
    .Out_Valid   (out_valid1),
    .Out_Ready   (out_ready1),
    .Out_Value   (out_value1),
    .Out_Row_End (out_row_end1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [31:0] v);
    int guard = 0;
    in_valid = 1'b1;
    in_value = v;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("push_timeout", guard, 0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: random ready with a 3-cycle stall on beat 5,
  // 2: always ready while upstream keeps offering changing values.
  task automatic collect(input logic [31:0] e [4], input int mode, input int nbeats);
    int   k = 0;
    int   guard = 0;
    int   stall = 0;
    logic r;
    check("out_valid_rise", out_valid, 1);
    while (k < nbeats) begin
      if (guard >= 400) begin
        check("collect_timeout", k, nbeats);
        break;
      end
      guard++;
      check("out_valid", out_valid, 1);
      check("out_value", out_value, e[(k % 8) / 2]);
      check("out_row_end", out_row_end, ((k % 8) == 7));
      if (mode == 2) begin
        in_valid = 1'b1;
        in_value = $urandom;
        check("in_ready_emit", in_ready, 0);
      end
      if (mode == 1) begin
        if (k == 5 && stall < 3) begin
          r = 1'b0;
          stall++;
        end else begin
          r = 1'($urandom_range(0, 1));
        end
      end else begin
        r = 1'b1;
      end
      out_ready = r;
      @(negedge clk);
      if (r) k++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},  in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
  endtask

  task automatic check_reset_out(input string tag);
    check({tag, "_in_ready"},    in_ready, 1);
    check({tag, "_out_valid"},   out_valid, 0);
    check({tag, "_out_value"},   out_value, 0);
    check({tag, "_out_row_end"}, out_row_end, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d", tests);
    $fatal(1);
  end

  initial begin
    vecs[0].din  = '{32'd4, 32'd8, 32'd12, 32'd16};
    vecs[0].dout = '{32'd1, 32'd2, 32'd3, 32'd4};
    vecs[0].mode = 0;
    vecs[1].din  = '{32'd7, 32'd3, 32'd0, 32'hFFFF_FFFF};
    vecs[1].dout = '{32'd1, 32'd0, 32'd0, 32'h3FFF_FFFF};
    vecs[1].mode = 0;
    vecs[2].din  = '{32'd100, 32'd5, 32'd2, 32'd9};
    vecs[2].dout = '{32'd25, 32'd1, 32'd0, 32'd2};
    vecs[2].mode = 1;
    vecs[3].din  = '{32'd1024, 32'd1025, 32'd1026, 32'd1027};
    vecs[3].dout = '{32'd256, 32'd256, 32'd256, 32'd256};
    vecs[3].mode = 2;
    vecs[4].din  = '{32'd40, 32'd80, 32'd120, 32'd160};
    vecs[4].dout = '{32'd10, 32'd20, 32'd30, 32'd40};
    vecs[4].mode = 0;

    rst = 1'b1;
    in_valid = 1'b0; in_value = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_value1 = '0; out_ready1 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_out("reset");
    check("reset1_in_ready",  in_ready1, 1);
    check("reset1_out_valid", out_valid1, 0);
    check("reset1_out_value", out_value1, 0);

    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 4; j++) push(vecs[i].din[j]);
      collect(vecs[i].dout, vecs[i].mode, 16);
      check_idle("after_rows");
    end

    // Reset with a partial row of two inputs.
    push(32'd100);
    push(32'd200);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_out("rst_fill");
    for (int j = 0; j < 4; j++) push(vecs[0].din[j]);
    collect(vecs[0].dout, 0, 16);
    check_idle("rst_fill_after");

    // Reset in the second output row at beat 3.
    for (int j = 0; j < 4; j++) push(vecs[2].din[j]);
    collect(vecs[2].dout, 0, 11);
    check("pre_rst_value", out_value, vecs[2].dout[1]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_out("rst_emit");
    for (int j = 0; j < 4; j++) push(vecs[1].din[j]);
    collect(vecs[1].dout, 0, 16);
    check_idle("rst_emit_after");

    // Single-value rows: 40 -> 10,10 per row, row end on every second beat.
    in_valid1 = 1'b1;
    in_value1 = 32'd40;
    check("r1_in_ready", in_ready1, 1);
    @(negedge clk);
    in_valid1 = 1'b0;
    for (int b = 0; b < 4; b++) begin
      check("r1_out_valid", out_valid1, 1);
      check("r1_in_ready_emit", in_ready1, 0);
      check("r1_out_value", out_value1, 32'd10);
      check("r1_out_row_end", out_row_end1, (b % 2) == 1);
      out_ready1 = 1'b1;
      @(negedge clk);
    end
    out_ready1 = 1'b0;
    check("r1_done_in_ready", in_ready1, 1);
    check("r1_done_out_valid", out_valid1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
